// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arb_pkg
//   Shared types and constants for the data memory arbiter: FSM state
//   encoding, doubleword size, default geometry and the address range check.
package data_mem_arb_pkg;

  typedef enum logic {
    S_CORE = 1'b0,
    S_DMA  = 1'b1
  } arb_state_e;

  localparam int unsigned DW_BYTES         = 8;
  localparam int unsigned DEF_MEM_BYTES    = 512;
  localparam int unsigned DEF_MAX_BURST    = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // A doubleword access is legal only if all eight bytes fit in the memory.
  // Plain unsigned 64-bit compare, so huge addresses never wrap into range.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned mem_bytes);
    return addr <= (64'(mem_bytes) - 64'(DW_BYTES));
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles the three buses around the arbiter:
//     core_* : MEM-stage request (req/we/addr/wdata in, stall/rdata/err out)
//     dma_*  : DMA burst request (req/we/addr/len/wdata in,
//              gnt/rdata/rvalid/done/err out)
//     mem_*  : single-port data memory (addr/wdata/write/read out, rdata in)
//   Modport slave is the arbiter's view, master is the view of the
//   surrounding core/DMA/memory environment.
interface data_mem_arbiter_if;
  import data_mem_arb_pkg::*;

  localparam int unsigned DW = DW_BYTES * 8;

  logic          core_req;
  logic          core_we;
  logic [63:0]   core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic          core_err;

  logic          dma_req;
  logic          dma_we;
  logic [63:0]   dma_addr;
  logic [2:0]    dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          dma_done;
  logic          dma_err;

  logic [63:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_stall, core_rdata, core_err,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid, dma_done, dma_err,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_stall, core_rdata, core_err,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid, dma_done, dma_err,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter_burst_ctr.sv
// mem_arb_burst_ctr
//   Burst bookkeeping for the DMA port. Captures start address, direction and
//   length when a burst is admitted, steps the beat counter on every executed
//   beat and accumulates a sticky out-of-range flag.
//   Ports:
//     clk, rst_n      : clock, async active-low reset
//     start_i         : capture addr_i/we_i/len_i, clear beat counter and error
//     addr_i, we_i,
//     len_i           : burst parameters (len_i = beats - 1)
//     beat_i          : a beat is executed this cycle
//     beat_addr_o     : byte address of the current beat
//     beat_ok_o       : current beat address is inside the memory
//     we_o            : captured direction
//     last_o          : current beat is the final one
//     err_o           : some executed beat of this burst was out of range
//   MAX_BURST must be a power of two between 2 and 8 (len is 3 bits).
module mem_arb_burst_ctr
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [63:0] addr_i,
  input  logic        we_i,
  input  logic [2:0]  len_i,
  input  logic        beat_i,
  output logic [63:0] beat_addr_o,
  output logic        beat_ok_o,
  output logic        we_o,
  output logic        last_o,
  output logic        err_o
);

  localparam int unsigned LEN_W = $clog2(MAX_BURST);

  logic [63:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [64:0]      sum;

  // One extra bit catches a base+offset carry past 2^64; such a beat is
  // treated as out of range instead of wrapping to a low address.
  assign sum         = {1'b0, base_q} + (65'(beat_q) << 3);
  assign beat_addr_o = sum[63:0];
  assign beat_ok_o   = !sum[64] && addr_in_range(sum[63:0], MEM_BYTES);
  assign we_o        = we_q;
  assign last_o      = (beat_q == len_q);
  assign err_o       = err_q;

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    beat_d = beat_q;
    we_d   = we_q;
    err_d  = err_q;
    if (start_i) begin
      base_d = addr_i;
      len_d  = len_i[LEN_W-1:0];
      we_d   = we_i;
      beat_d = '0;
      err_d  = 1'b0;
    end else if (beat_i) begin
      err_d = err_q | !beat_ok_o;
      if (!last_o) beat_d = beat_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      beat_q <= beat_d;
      we_q   <= we_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port 64-bit data memory between the MEM stage (core,
//   default owner, zero-latency reads) and a DMA port doing non-preemptable
//   bursts of 1..MAX_BURST doublewords. DMA gets in when the core is idle or
//   after STARVE_LIMIT consecutive contended cycles.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     bus        : core_*, dma_* and mem_* signals (slave modport)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_CORE | core owns memory; combinational pass-through, never stalled
//   S_DMA  | one DMA beat per cycle until the last beat; core is stalled
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = DEF_MEM_BYTES,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          start;
  logic          beat;
  logic [63:0]   beat_addr;
  logic          beat_ok;
  logic          burst_we;
  logic          burst_last;
  logic          burst_err;
  logic          core_ok;

  logic [63:0]   mem_addr_c;
  logic [63:0]   mem_wdata_c;
  logic          mem_read_c;
  logic          mem_write_c;
  logic          core_stall_c;
  logic [63:0]   core_rdata_c;
  logic          core_err_c;

  logic          dma_rvalid_q;
  logic [63:0]   dma_rdata_q;
  logic          dma_done_q;

  mem_arb_burst_ctr #(
    .MEM_BYTES (MEM_BYTES),
    .MAX_BURST (MAX_BURST)
  ) u_burst_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .addr_i      (bus.dma_addr),
    .we_i        (bus.dma_we),
    .len_i       (bus.dma_len),
    .beat_i      (beat),
    .beat_addr_o (beat_addr),
    .beat_ok_o   (beat_ok),
    .we_o        (burst_we),
    .last_o      (burst_last),
    .err_o       (burst_err)
  );

  assign core_ok = addr_in_range(bus.core_addr, MEM_BYTES);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    start        = 1'b0;
    beat         = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    core_stall_c = 1'b0;
    core_rdata_c = '0;
    core_err_c   = 1'b0;

    unique case (state_q)
      S_CORE: begin
        if (bus.core_req) begin
          mem_addr_c  = bus.core_addr;
          mem_wdata_c = bus.core_wdata;
          mem_read_c  = !bus.core_we && core_ok;
          mem_write_c = bus.core_we && core_ok;
          core_err_c  = !core_ok;
          if (!bus.core_we && core_ok) core_rdata_c = bus.mem_rdata;
        end

        if (!bus.dma_req) begin
          starve_d = '0;
        end else if (bus.core_req && starve_q != STARVE_MAX) begin
          starve_d = starve_q + SW'(1);
        end

        // A forced entry still serves the core in this cycle; the stall
        // starts with the first beat.
        if (bus.dma_req && (!bus.core_req || starve_q == STARVE_MAX)) begin
          state_d  = S_DMA;
          start    = 1'b1;
          starve_d = '0;
        end
      end

      S_DMA: begin
        beat         = 1'b1;
        starve_d     = '0;
        mem_addr_c   = beat_addr;
        mem_wdata_c  = bus.dma_wdata;
        mem_read_c   = !burst_we && beat_ok;
        mem_write_c  = burst_we && beat_ok;
        core_stall_c = bus.core_req;
        if (burst_last) state_d = S_CORE;
      end

      default: state_d = S_CORE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CORE;
      starve_q     <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      dma_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      dma_rvalid_q <= beat && !burst_we;
      dma_rdata_q  <= (beat && !burst_we && beat_ok) ? bus.mem_rdata : '0;
      dma_done_q   <= beat && burst_last;
    end
  end

  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  // Strobes are killed directly by rst_n so a core request held through
  // reset can never commit a write.
  assign bus.mem_read   = mem_read_c && rst_n;
  assign bus.mem_write  = mem_write_c && rst_n;

  assign bus.core_stall = core_stall_c;
  assign bus.core_rdata = core_rdata_c;
  assign bus.core_err   = core_err_c;

  assign bus.dma_gnt    = beat;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_done   = dma_done_q;
  assign bus.dma_err    = dma_done_q && burst_err;

endmodule
